imem_line_server: RTL and testbench
===================================

# imem_line_server

Instruction-memory responder feeding the fetch stage's 128-bit `instruction_mem_in` line port. On an instruction-cache miss request it reads four consecutive 32-bit words from its internal word store. Each word read takes a programmable number of wait cycles, so the block models slow main memory. It then returns the assembled line with a one-cycle valid pulse. A side-band load port lets the bench or boot logic preload the program image.

## Interface
Parameters:
- `DEPTH_WORDS`, 256: words of storage; power of two, ≥ 4.
- `WAIT_CYCLES`, 2: idle cycles before each word read; 0 is legal.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  reset. One clock; reset is asynchronous and active-high.
- `req_valid`  in  1  miss request from fetch.
- `req_addr`  in  32  byte address of the missing instruction.
- `req_ready`  out  1  high only in IDLE.
- `line_valid`  out  1  one-cycle pulse: `line_data`/`line_addr` are new.
- `line_data`  out  128  returned line; word at offset 0 in [31:0], offset 3 in [127:96].
- `line_addr`  out  32  16-byte-aligned address of the returned line.
- `busy`  out  1  high in WAIT, READ and RESP.
- `load_en`  in  1  write strobe for preload.
- `load_addr`  in  log2(DEPTH_WORDS)  word index for the write.
- `load_data`  in  32  word written.

## Operation
- FSM states: IDLE, WAIT, READ, RESP.
- IDLE: `req_ready`=1. On `req_valid`:
  - latch base = `req_addr` & ~32'hF;
  - set beat=0;
  - go to WAIT with counter=`WAIT_CYCLES`, or straight to READ if `WAIT_CYCLES`=0.
- WAIT: counter decrements each cycle. When it reaches 0, go to READ.
- READ (one cycle): assembly lane[beat] ← store[(base>>2)+beat].
  - beat<3: beat++ and re-enter WAIT (or stay in READ if `WAIT_CYCLES`=0).
  - beat=3: go to RESP.
- On the READ→RESP edge, `line_data` ← assembled lanes (including the word just read) and `line_addr` ← base.
- RESP: `line_valid`=1 for exactly one cycle, then IDLE.
- `line_data` and `line_addr` hold their values until the next RESP; they never show partial fills.
- Word index wraps modulo `DEPTH_WORDS`; upper address bits are discarded. `req_addr`[3:0] is ignored.
- `req_valid` while not in IDLE is ignored. The requester holds it until `req_ready`; there is no queueing.
- Load port is always active, including during a fill.
  - A word not yet read returns the new value.
  - A word already read keeps its old value.
  - Load and READ to the same index in the same cycle: read returns the old data (read-before-write).
- `rst` mid-operation: FSM goes to IDLE, the fill is abandoned, and no `line_valid` is issued. Storage contents are not cleared.

## Timing
- Reset values: `req_ready`=1, `busy`=0, `line_valid`=0, `line_data`=0, `line_addr`=0, beat=0, counter=0.
- `req_ready`, `busy` and `line_valid` are decoded from registered state (Moore); no input-to-output combinational path.
- Request accepted at edge k → `line_valid` high from edge k+4·(`WAIT_CYCLES`+1) for one cycle.
  - Default latency: 12 cycles.
  - `WAIT_CYCLES`=0: 4 cycles.
- Next request is accepted no earlier than the edge after the RESP cycle. Back-to-back line period is 4·(W+1)+2 cycles.
- Storage write on the rising edge when `load_en`=1. Read is combinational from the array and sampled in READ.

## Structure
- Shared package / header `imem_defs`: `LINE_WORDS`=4, `LINE_BYTES`=16, `LINE_W`=128, FSM state encodings.
- Sub-module `imem_word_array`: `DEPTH_WORDS`×32 storage, one sync write port, one async read port, no reset.
- Top holds the FSM, wait counter, beat counter, 128-bit assembly buffer and output registers.

## Test plan
- Preload words 0–7 with 32'h1000_0000+i. Request `req_addr`=32'h14 → after 12 cycles one `line_valid` pulse; `line_addr`=32'h10; `line_data`={32'h1000_0007,…_0006,…_0005,…_0004}.
- `WAIT_CYCLES`=0, `req_addr`=0 → `line_valid` exactly 4 cycles after accept; `req_ready` low for 5 cycles.
- `DEPTH_WORDS`=256, `req_addr`=32'h0000_0400 → returns words 0–3 (wrap); `line_addr`=32'h400.
- During the fill of line 0, load word 3 ← 32'hDEAD_BEEF before beat 3 and word 0 ← 32'hCAFE after beat 0 → `line_data`[127:96]=DEADBEEF and [31:0]=old word 0.
- `req_valid` held high through the response → second fill starts only on the edge after the RESP cycle, and exactly one pulse per fill.
- Assert `rst` mid-fill after beat 1 → no `line_valid`; outputs back to reset values; storage intact on the next request.

Source files
------------

// File: rtl/imem_defs.sv
// Shared line geometry and FSM encoding for the instruction-memory line server.
package imem_defs;

  localparam int LINE_WORDS = 4;
  localparam int LINE_BYTES = 16;
  localparam int LINE_W     = 128;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_READ = 2'd2,
    ST_RESP = 2'd3
  } state_t;

endpackage

// File: rtl/imem_word_array.sv
// Word store: one synchronous write port, one combinational read port.
module imem_word_array #(
  parameter int DEPTH_WORDS = 256,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [31:0]   i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [31:0]   o_rdata
);

  logic [31:0] r_mem [DEPTH_WORDS];

  // NOTE: storage has no reset; a preloaded image must survive rst, and a
  // resettable array would also stop mapping onto RAM.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  // Same-cycle write lands at the edge, so a concurrent read sees old data.
  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/imem_line_server.sv
// Fetches a 4-word instruction line with programmable per-word wait states.
module imem_line_server
  import imem_defs::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           req_valid,
  input  logic [31:0]                    req_addr,
  output logic                           req_ready,
  output logic                           line_valid,
  output logic [LINE_W-1:0]              line_data,
  output logic [31:0]                    line_addr,
  output logic                           busy,
  input  logic                           load_en,
  input  logic [$clog2(DEPTH_WORDS)-1:0] load_addr,
  input  logic [31:0]                    load_data
);

  localparam int          AW        = $clog2(DEPTH_WORDS);
  localparam int          CW        = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] CNT_LOAD  = CW'(WAIT_CYCLES);
  localparam logic [31:0] LINE_MASK = 32'(LINE_BYTES - 1);
  // Entry state for each beat: zero wait states skip WAIT entirely.
  localparam state_t      ST_FILL   = (WAIT_CYCLES == 0) ? ST_READ : ST_WAIT;

  state_t                r_state;
  state_t                w_state_next;
  logic [CW-1:0]         r_cnt;
  logic [1:0]            r_beat;
  logic [31:0]           r_base;
  logic [LINE_W-33:0]    r_asm;
  logic [LINE_W-1:0]     r_line_data;
  logic [31:0]           r_line_addr;
  logic [AW-1:0]         w_rd_idx;
  logic [31:0]           w_rd_data;

  // Index wraps naturally in AW bits; upper address bits drop out.
  assign w_rd_idx = r_base[AW+1:2] + AW'(r_beat);

  imem_word_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_array (
    .clk     (clk),
    .i_we    (load_en),
    .i_waddr (load_addr),
    .i_wdata (load_data),
    .i_raddr (w_rd_idx),
    .o_rdata (w_rd_data)
  );

  // NOTE: state registers use non-blocking assignment so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_next;
  end

  // NOTE: default first so every path assigns w_state_next and no latch forms.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (req_valid) w_state_next = ST_FILL;
      // Leaving at count 1 makes WAIT last exactly WAIT_CYCLES cycles.
      ST_WAIT: if (r_cnt <= CW'(1)) w_state_next = ST_READ;
      ST_READ: w_state_next = (r_beat == 2'd3) ? ST_RESP : ST_FILL;
      ST_RESP: w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt       <= '0;
      r_beat      <= '0;
      r_base      <= '0;
      r_asm       <= '0;
      r_line_data <= '0;
      r_line_addr <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (req_valid) begin
            r_base <= req_addr & ~LINE_MASK;
            r_beat <= 2'd0;
            r_cnt  <= CNT_LOAD;
          end
        end
        ST_WAIT: r_cnt <= r_cnt - CW'(1);
        ST_READ: begin
          case (r_beat)
            2'd0: r_asm[31:0]  <= w_rd_data;
            2'd1: r_asm[63:32] <= w_rd_data;
            2'd2: r_asm[95:64] <= w_rd_data;
            default: begin
              // Publish the whole line at once so outputs never show a partial fill.
              r_line_data <= {w_rd_data, r_asm};
              r_line_addr <= r_base;
            end
          endcase
          if (r_beat != 2'd3) begin
            r_beat <= r_beat + 2'd1;
            r_cnt  <= CNT_LOAD;
          end
        end
        default: ;
      endcase
    end
  end

  assign req_ready  = (r_state == ST_IDLE);
  assign busy       = (r_state != ST_IDLE);
  assign line_valid = (r_state == ST_RESP);
  assign line_data  = r_line_data;
  assign line_addr  = r_line_addr;

endmodule

// File: tb/tb_imem_line_server.sv
// Scoreboard bench: default-wait and zero-wait instances share load port and reset.
module tb_imem_line_server;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         load_en = 1'b0;
  logic [7:0]   load_addr = '0;
  logic [31:0]  load_data = '0;

  logic         m_req_valid = 1'b0;
  logic [31:0]  m_req_addr = '0;
  logic         m_req_ready, m_line_valid, m_busy;
  logic [127:0] m_line_data;
  logic [31:0]  m_line_addr;

  logic         z_req_valid = 1'b0;
  logic [31:0]  z_req_addr = '0;
  logic         z_req_ready, z_line_valid, z_busy;
  logic [127:0] z_line_data;
  logic [31:0]  z_line_addr;

  int n_vec  = 0;
  int n_miss = 0;
  int cyc    = 0;

  typedef struct {
    logic [31:0]  addr;
    logic [127:0] data;
    int           due;
  } exp_t;

  exp_t        q_m[$];
  exp_t        q_z[$];
  logic [31:0] mem_model [256];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  imem_line_server u_dut (
    .clk(clk), .rst(rst),
    .req_valid(m_req_valid), .req_addr(m_req_addr), .req_ready(m_req_ready),
    .line_valid(m_line_valid), .line_data(m_line_data), .line_addr(m_line_addr),
    .busy(m_busy), .load_en(load_en), .load_addr(load_addr), .load_data(load_data)
  );

  imem_line_server #(.DEPTH_WORDS(256), .WAIT_CYCLES(0)) u_dut_w0 (
    .clk(clk), .rst(rst),
    .req_valid(z_req_valid), .req_addr(z_req_addr), .req_ready(z_req_ready),
    .line_valid(z_line_valid), .line_data(z_line_data), .line_addr(z_line_addr),
    .busy(z_busy), .load_en(load_en), .load_addr(load_addr), .load_data(load_data)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] model_line(input logic [31:0] a);
    logic [7:0] b;
    b = a[9:2] & 8'hFC;
    return {mem_model[b + 8'd3], mem_model[b + 8'd2], mem_model[b + 8'd1], mem_model[b]};
  endfunction

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Called at a negedge; the write lands on the next rising edge.
  task automatic load_word(input logic [7:0] a, input logic [31:0] d);
    load_en   = 1'b1;
    load_addr = a;
    load_data = d;
    @(negedge clk);
    load_en = 1'b0;
    mem_model[a] = d;
  endtask

  task automatic req(input bit which, input logic [31:0] a, input logic [127:0] d,
                     input bit hold, output int acc);
    int   n;
    exp_t e;
    if (which) begin z_req_valid = 1'b1; z_req_addr = a; end
    else       begin m_req_valid = 1'b1; m_req_addr = a; end
    n = 0;
    while (!(which ? z_req_ready : m_req_ready) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!(which ? z_req_ready : m_req_ready)) begin
      check("req_accept_timeout", 0, 1);
      m_req_valid = 1'b0;
      z_req_valid = 1'b0;
      acc = -1;
      return;
    end
    acc    = cyc + 1;
    e.addr = a & ~32'hF;
    e.data = d;
    e.due  = acc + (which ? 4 : 12);
    if (which) q_z.push_back(e);
    else       q_m.push_back(e);
    @(negedge clk);
    if (!hold) begin
      m_req_valid = 1'b0;
      z_req_valid = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((q_m.size() + q_z.size()) != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", q_m.size() + q_z.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst && m_line_valid) begin
      if (q_m.size() == 0) check("m_spurious_pulse", 1, 0);
      else begin
        e = q_m.pop_front();
        check("m_line_addr", m_line_addr, e.addr);
        check("m_line_data", m_line_data, e.data);
        check("m_latency", cyc, e.due);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst && z_line_valid) begin
      if (q_z.size() == 0) check("z_spurious_pulse", 1, 0);
      else begin
        e = q_z.pop_front();
        check("z_line_addr", z_line_addr, e.addr);
        check("z_line_data", z_line_data, e.data);
        check("z_latency", cyc, e.due);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, acc2, n;
    logic [127:0] exp;

    for (int i = 0; i < 256; i++) mem_model[i] = '0;
    repeat (3) @(negedge clk);
    check("rst_m_ready", m_req_ready, 1);
    check("rst_m_busy", m_busy, 0);
    check("rst_m_valid", m_line_valid, 0);
    check("rst_m_data", m_line_data, 0);
    check("rst_m_addr", m_line_addr, 0);
    check("rst_z_ready", z_req_ready, 1);
    check("rst_z_busy", z_busy, 0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 16; i++) load_word(8'(i), 32'h1000_0000 + i);
    for (int i = 252; i < 256; i++) load_word(8'(i), 32'hA000_0000 + i);

    // Basic fill, offset bits ignored.
    req(0, 32'h14, 128'h1000_0007_1000_0006_1000_0005_1000_0004, 0, acc);
    check("m_busy_fill", m_busy, 1);
    check("m_ready_fill", m_req_ready, 0);
    wait_idle();

    // Zero wait states: 4-cycle latency, ready low for 5 cycles.
    req(1, 32'h0, 128'h1000_0003_1000_0002_1000_0001_1000_0000, 0, acc);
    n = 0;
    while (!z_req_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    check("z_ready_low_cycles", n, 5);
    wait_idle();

    // Index wraps modulo depth; line_addr keeps upper bits.
    req(0, 32'h0000_0400, 128'h1000_0003_1000_0002_1000_0001_1000_0000, 0, acc);
    wait_idle();
    req(0, 32'hFFFF_FFFC, 128'hA000_00FF_A000_00FE_A000_00FD_A000_00FC, 0, acc);
    wait_idle();

    // Loads during a fill: word 0 written on its own read edge, word 3 before its read.
    exp = {32'hDEAD_BEEF, mem_model[2], mem_model[1], mem_model[0]};
    req(0, 32'h0, exp, 0, acc);
    wait_cyc(acc + 2);
    load_word(8'd0, 32'h0000_CAFE);
    wait_cyc(acc + 5);
    load_word(8'd3, 32'hDEAD_BEEF);
    wait_idle();
    req(1, 32'h0, model_line(32'h0), 0, acc);
    wait_idle();

    // Request held through the response: next accept exactly one period later.
    req(0, 32'h24, model_line(32'h20), 1, acc);
    req(0, 32'h24, model_line(32'h20), 0, acc2);
    check("b2b_period", acc2 - acc, 14);
    wait_idle();

    // Reset after beat 1: no pulse, outputs cleared, storage kept.
    req(0, 32'h18, model_line(32'h10), 0, acc);
    wait_cyc(acc + 6);
    rst = 1'b1;
    q_m.delete();
    @(negedge clk);
    check("mid_rst_ready", m_req_ready, 1);
    check("mid_rst_busy", m_busy, 0);
    check("mid_rst_valid", m_line_valid, 0);
    check("mid_rst_data", m_line_data, 0);
    check("mid_rst_addr", m_line_addr, 0);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    req(0, 32'h10, 128'h1000_0007_1000_0006_1000_0005_1000_0004, 0, acc);
    wait_idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
